data_stack: RTL and testbench

//  Data-stack unit of the stack16 core, directly upstream of BitsliceALU.

---
 rtl/stack16_pkg.sv | 16 +
 rtl/data_stack_if.sv | 31 +++
 rtl/stack_spill_ram.sv | 21 ++
 rtl/data_stack.sv | 123 ++++++++++++
 tb/tb_data_stack.sv | 156 +++++++++++++++
 5 files changed

// File: rtl/stack16_pkg.sv
// Shared constants and stack-operation encodings for the stack16 data-stack slice.
package stack16_pkg;
  localparam int unsigned WIDTH = 16;
  localparam int unsigned DEPTH = 16;

  typedef enum logic [2:0] {
    OP_NOP    = 3'b000,
    OP_PUSH   = 3'b001,
    OP_POP    = 3'b010,
    OP_BINARY = 3'b011,
    OP_UNARY  = 3'b100,
    OP_SWAP   = 3'b101,
    OP_DUP    = 3'b110,
    OP_OVER   = 3'b111
  } stack_op_e;
endpackage

// File: rtl/data_stack_if.sv
// Operation/operand bundle between the stack16 sequencer, the data stack and the ALU.
interface data_stack_if
  import stack16_pkg::*;
#(
  parameter int unsigned WIDTH = stack16_pkg::WIDTH,
  parameter int unsigned DEPTH = stack16_pkg::DEPTH
);
  localparam int unsigned DW = $clog2(DEPTH + 3);

  stack_op_e          StackOp;
  logic [WIDTH-1:0]   PushData;
  logic [WIDTH-1:0]   AluQ;
  logic               ClearErr;
  logic [WIDTH-1:0]   Tos;
  logic [WIDTH-1:0]   Nos;
  logic [DW-1:0]      Depth;
  logic               Empty;
  logic               Full;
  logic               Overflow;
  logic               Underflow;

  modport master (
    output StackOp, PushData, AluQ, ClearErr,
    input  Tos, Nos, Depth, Empty, Full, Overflow, Underflow
  );

  modport slave (
    input  StackOp, PushData, AluQ, ClearErr,
    output Tos, Nos, Depth, Empty, Full, Overflow, Underflow
  );
endinterface

// File: rtl/stack_spill_ram.sv
// Spill register file for stack entries below Nos: synchronous write, asynchronous read.
module stack_spill_ram #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic             Clock,
  input  logic             WrEn,
  input  logic [AW-1:0]    WrAddr,
  input  logic [WIDTH-1:0] WrData,
  input  logic [AW-1:0]    RdAddr,
  output logic [WIDTH-1:0] RdData
);
  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge Clock) begin
    if (WrEn) mem[WrAddr] <= WrData;
  end

  assign RdData = mem[RdAddr];
endmodule

// File: rtl/data_stack.sv
// Data stack: Tos/Nos registers feeding the ALU, spill file below, depth tracking and sticky errors.
module data_stack
  import stack16_pkg::*;
#(
  parameter int unsigned WIDTH = stack16_pkg::WIDTH,
  parameter int unsigned DEPTH = stack16_pkg::DEPTH
) (
  input  logic       Clock,
  input  logic       Reset_n,
  data_stack_if.slave bus
);
  localparam int unsigned DW = $clog2(DEPTH + 3);
  localparam int unsigned SW = $clog2(DEPTH + 1);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] tos_q, tos_d, nos_q, nos_d;
  logic [DW-1:0]    depth_q, depth_d;
  logic [SW-1:0]    sp_q, sp_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic             ovf_set, unf_set;
  logic             wr_en;
  logic [WIDTH-1:0] wr_data, rd_data, spill_top;
  logic             full, has1, has2;

  stack_spill_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_spill (
    .Clock  (Clock),
    .WrEn   (wr_en),
    .WrAddr (AW'(sp_q)),
    .WrData (wr_data),
    .RdAddr (AW'(sp_q - SW'(1))),
    .RdData (rd_data)
  );

  assign spill_top = (sp_q == '0) ? '0 : rd_data;
  assign full      = (depth_q == DW'(DEPTH + 2));
  assign has1      = (depth_q != '0);
  assign has2      = (depth_q >= DW'(2));

  always_comb begin
    tos_d   = tos_q;
    nos_d   = nos_q;
    depth_d = depth_q;
    sp_d    = sp_q;
    wr_en   = 1'b0;
    wr_data = nos_q;
    ovf_set = 1'b0;
    unf_set = 1'b0;
    unique case (bus.StackOp)
      OP_NOP: ;
      OP_PUSH, OP_DUP, OP_OVER: begin
        // Depth is checked before fullness so DUP/OVER on a short stack report underflow.
        if ((bus.StackOp == OP_DUP && !has1) || (bus.StackOp == OP_OVER && !has2)) begin
          unf_set = 1'b1;
        end else if (full) begin
          ovf_set = 1'b1;
        end else begin
          if (has2) begin
            wr_en = 1'b1;
            sp_d  = sp_q + SW'(1);
          end
          nos_d   = tos_q;
          depth_d = depth_q + DW'(1);
          unique case (bus.StackOp)
            OP_PUSH: tos_d = bus.PushData;
            OP_DUP:  tos_d = tos_q;
            default: tos_d = nos_q;
          endcase
        end
      end
      OP_POP, OP_BINARY: begin
        if ((bus.StackOp == OP_POP) ? !has1 : !has2) begin
          unf_set = 1'b1;
        end else begin
          tos_d   = (bus.StackOp == OP_POP) ? nos_q : bus.AluQ;
          nos_d   = spill_top;
          depth_d = depth_q - DW'(1);
          if (sp_q != '0) sp_d = sp_q - SW'(1);
        end
      end
      OP_UNARY: begin
        if (!has1) unf_set = 1'b1;
        else       tos_d   = bus.AluQ;
      end
      OP_SWAP: begin
        if (!has2) begin
          unf_set = 1'b1;
        end else begin
          tos_d = nos_q;
          nos_d = tos_q;
        end
      end
      default: ;
    endcase
    ovf_d = (ovf_q & ~bus.ClearErr) | ovf_set;
    unf_d = (unf_q & ~bus.ClearErr) | unf_set;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      tos_q   <= '0;
      nos_q   <= '0;
      depth_q <= '0;
      sp_q    <= '0;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      tos_q   <= tos_d;
      nos_q   <= nos_d;
      depth_q <= depth_d;
      sp_q    <= sp_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  assign bus.Tos       = tos_q;
  assign bus.Nos       = nos_q;
  assign bus.Depth     = depth_q;
  assign bus.Empty     = (depth_q == '0);
  assign bus.Full      = full;
  assign bus.Overflow  = ovf_q;
  assign bus.Underflow = unf_q;
endmodule

// File: tb/tb_data_stack.sv
// Bench for data_stack with a behavioural adder standing in for the ALU (A+B).
module tb_data_stack;
  import stack16_pkg::*;

  typedef struct {
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  depth;
    logic        ovf;
    logic        unf;
  } exp_t;

  typedef struct {
    stack_op_e   op;
    logic [15:0] data;
    logic        clr;
    logic [15:0] tos;
    logic [15:0] nos;
    logic [4:0]  depth;
    logic        ovf;
    logic        unf;
  } vec_t;

  logic Clock;
  logic Reset_n;
  int   errors;
  int   checks;
  exp_t  sbq[$];
  string nameq[$];
  vec_t  vecs[25];

  data_stack_if #(.WIDTH(16), .DEPTH(16)) bus ();

  data_stack #(.WIDTH(16), .DEPTH(16)) dut (
    .Clock   (Clock),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  assign bus.AluQ = bus.Tos + bus.Nos;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  function automatic exp_t mk(logic [15:0] t, logic [15:0] n, logic [4:0] d, logic o, logic u);
    exp_t e;
    e.tos = t; e.nos = n; e.depth = d; e.ovf = o; e.unf = u;
    return e;
  endfunction

  task automatic compare(string nm, exp_t e);
    logic ee, ef;
    ee = (e.depth == 5'd0);
    ef = (e.depth == 5'd18);
    checks++;
    if (bus.Tos !== e.tos || bus.Nos !== e.nos || bus.Depth !== e.depth ||
        bus.Empty !== ee || bus.Full !== ef || bus.Overflow !== e.ovf || bus.Underflow !== e.unf) begin
      errors++;
      $display("FAIL %s: got tos=%h nos=%h depth=%0d empty=%b full=%b ovf=%b unf=%b; expected tos=%h nos=%h depth=%0d empty=%b full=%b ovf=%b unf=%b",
               nm, bus.Tos, bus.Nos, bus.Depth, bus.Empty, bus.Full, bus.Overflow, bus.Underflow,
               e.tos, e.nos, e.depth, ee, ef, e.ovf, e.unf);
    end
  endtask

  task automatic step(stack_op_e op, logic [15:0] d, logic c, exp_t e, string nm);
    @(negedge Clock);
    bus.StackOp  = op;
    bus.PushData = d;
    bus.ClearErr = c;
    sbq.push_back(e);
    nameq.push_back(nm);
    @(posedge Clock);
    #1;
    compare(nameq.pop_front(), sbq.pop_front());
  endtask

  initial begin
    errors = 0;
    checks = 0;
    bus.StackOp  = OP_NOP;
    bus.PushData = '0;
    bus.ClearErr = 1'b0;
    Reset_n      = 1'b0;

    vecs[0]  = '{OP_PUSH,   16'h4444, 1'b0, 16'h4444, 16'h0000, 5'd1, 1'b0, 1'b0};
    vecs[1]  = '{OP_PUSH,   16'h2345, 1'b0, 16'h2345, 16'h4444, 5'd2, 1'b0, 1'b0};
    vecs[2]  = '{OP_BINARY, 16'h0000, 1'b0, 16'h6789, 16'h0000, 5'd1, 1'b0, 1'b0};
    vecs[3]  = '{OP_PUSH,   16'h0001, 1'b0, 16'h0001, 16'h6789, 5'd2, 1'b0, 1'b0};
    vecs[4]  = '{OP_POP,    16'h0000, 1'b0, 16'h6789, 16'h0000, 5'd1, 1'b0, 1'b0};
    vecs[5]  = '{OP_POP,    16'h0000, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0};
    vecs[6]  = '{OP_POP,    16'h0000, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1};
    vecs[7]  = '{OP_NOP,    16'h0000, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1};
    vecs[8]  = '{OP_NOP,    16'h0000, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0};
    vecs[9]  = '{OP_PUSH,   16'h000A, 1'b0, 16'h000A, 16'h0000, 5'd1, 1'b0, 1'b0};
    vecs[10] = '{OP_PUSH,   16'h000B, 1'b0, 16'h000B, 16'h000A, 5'd2, 1'b0, 1'b0};
    vecs[11] = '{OP_SWAP,   16'h0000, 1'b0, 16'h000A, 16'h000B, 5'd2, 1'b0, 1'b0};
    vecs[12] = '{OP_OVER,   16'h0000, 1'b0, 16'h000B, 16'h000A, 5'd3, 1'b0, 1'b0};
    vecs[13] = '{OP_DUP,    16'h0000, 1'b0, 16'h000B, 16'h000B, 5'd4, 1'b0, 1'b0};
    vecs[14] = '{OP_UNARY,  16'h0000, 1'b0, 16'h0016, 16'h000B, 5'd4, 1'b0, 1'b0};
    vecs[15] = '{OP_BINARY, 16'h0000, 1'b0, 16'h0021, 16'h000A, 5'd3, 1'b0, 1'b0};
    vecs[16] = '{OP_POP,    16'h0000, 1'b0, 16'h000A, 16'h000B, 5'd2, 1'b0, 1'b0};
    vecs[17] = '{OP_SWAP,   16'h0000, 1'b0, 16'h000B, 16'h000A, 5'd2, 1'b0, 1'b0};
    vecs[18] = '{OP_POP,    16'h0000, 1'b0, 16'h000A, 16'h0000, 5'd1, 1'b0, 1'b0};
    vecs[19] = '{OP_SWAP,   16'h0000, 1'b0, 16'h000A, 16'h0000, 5'd1, 1'b0, 1'b1};
    vecs[20] = '{OP_BINARY, 16'h0000, 1'b1, 16'h000A, 16'h0000, 5'd1, 1'b0, 1'b1};
    vecs[21] = '{OP_POP,    16'h0000, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0};
    vecs[22] = '{OP_POP,    16'h0000, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1};
    vecs[23] = '{OP_OVER,   16'h0000, 1'b0, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b1};
    vecs[24] = '{OP_NOP,    16'h0000, 1'b1, 16'h0000, 16'h0000, 5'd0, 1'b0, 1'b0};

    #12;
    compare("reset_state", mk(16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    @(negedge Clock);
    Reset_n = 1'b1;

    for (int i = 0; i < 25; i++) begin
      step(vecs[i].op, vecs[i].data, vecs[i].clr,
           mk(vecs[i].tos, vecs[i].nos, vecs[i].depth, vecs[i].ovf, vecs[i].unf),
           $sformatf("vec%0d", i));
    end

    // Fill to capacity, overflow, then drain in LIFO order.
    for (int i = 1; i <= 18; i++) begin
      step(OP_PUSH, 16'(i), 1'b0, mk(16'(i), 16'(i - 1), 5'(i), 1'b0, 1'b0), $sformatf("fill%0d", i));
    end
    step(OP_PUSH, 16'h0013, 1'b0, mk(16'h0012, 16'h0011, 5'd18, 1'b1, 1'b0), "push_when_full");
    step(OP_DUP,  16'h0000, 1'b1, mk(16'h0012, 16'h0011, 5'd18, 1'b1, 1'b0), "dup_full_clr");
    step(OP_NOP,  16'h0000, 1'b1, mk(16'h0012, 16'h0011, 5'd18, 1'b0, 1'b0), "clear_ovf");
    for (int k = 1; k <= 18; k++) begin
      int n;
      n = 18 - k;
      step(OP_POP, 16'h0, 1'b0, mk(16'(n), (n >= 2) ? 16'(n - 1) : 16'h0, 5'(n), 1'b0, 1'b0),
           $sformatf("drain%0d", k));
    end

    // Asynchronous reset asserted between clock edges.
    for (int i = 1; i <= 5; i++) begin
      step(OP_PUSH, 16'h0100 + 16'(i), 1'b0,
           mk(16'h0100 + 16'(i), (i >= 2) ? 16'h0100 + 16'(i - 1) : 16'h0, 5'(i), 1'b0, 1'b0),
           $sformatf("pre_reset%0d", i));
    end
    @(negedge Clock);
    bus.StackOp = OP_NOP;
    #2;
    Reset_n = 1'b0;
    #1;
    compare("async_reset", mk(16'h0, 16'h0, 5'd0, 1'b0, 1'b0));
    @(negedge Clock);
    Reset_n = 1'b1;
    step(OP_POP, 16'h0000, 1'b1, mk(16'h0, 16'h0, 5'd0, 1'b0, 1'b1), "post_reset_clr_vs_unf");
    step(OP_PUSH, 16'hBEEF, 1'b0, mk(16'hBEEF, 16'h0, 5'd1, 1'b0, 1'b1), "post_reset_push");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
